adder_subtractor_4_bit: RTL and testbench
=========================================

Name: adder_subtractor_4_bit

Overview:
- 4-bit two's-complement adder/subtractor with one mode control.
- M=0 adds the operands; M=1 subtracts num2 from num1.
- Result and carry/no-borrow flag are registered, giving one clock of latency.
- Leaf arithmetic block used by datapath/ALU logic. Ripple-carry core with XOR-controlled operand inversion.

Parameters:
- None. Width is fixed at 4 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- num1  input  4  operand A (minuend when subtracting).
- num2  input  4  operand B (subtrahend when subtracting).
- M  input  1  mode: 0 = add, 1 = subtract.
- ans  output  4  registered 4-bit result.
- C4  output  1  registered carry-out of bit 3.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n low forces ans=4'b0000 and C4=0 immediately, regardless of clk.
  - Outputs hold these values while rst_n is low.
  - The first capture occurs on the first rising clk edge after rst_n deasserts.
- Datapath (combinational, ahead of the output register):
  - b_eff[i] = num2[i] XOR M.
  - Carry-in c0 = M.
  - 4-stage ripple chain: s[i] = num1[i]^b_eff[i]^c[i]; c[i+1] = majority(num1[i], b_eff[i], c[i]).
  - C4 source = c4 of the chain.
- Add (M=0): {C4,ans} = num1 + num2 (5-bit unsigned sum). C4=1 exactly when num1+num2 > 15.
- Subtract (M=1):
  - ans = (num1 - num2) mod 16.
  - C4 = 1 when num1 >= num2 (no borrow); C4 = 0 when num1 < num2 (borrow).
  - C4=1 for num1==num2, including 0-0 and 15-15.
- Latency:
  - Inputs sampled on rising clk edge N; ans/C4 reflect them from edge N onward, until edge N+1.
  - New operands and mode may be applied every cycle; no handshake, no stall.
- Mode change: a change of M takes effect on the next edge exactly like an operand change. No intermediate state.
- Wrap-around:
  - 15+1 gives ans=0, C4=1.
  - 0-1 gives ans=15, C4=0.
- No signed-overflow output. The consumer derives it if needed.
- Reset mid-operation: asynchronous clear wins immediately; any in-flight result is discarded.
- X-free requirement: with known inputs after reset, outputs are never X.

Decomposition:
- Shared package holds:
  - localparam WIDTH=4.
  - MODE_ADD=1'b0, MODE_SUB=1'b1 constants.
- Sub-module full_adder (a, b, cin -> sum, cout). Instantiated 4 times in the ripple chain.
- Operand inversion, carry-in and the output register live in the top module.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with num1=9, num2=3 applied -> ans=0, C4=0 immediately, without a clk edge; hold until release.
- Add sweep: M=0, all 256 (num1, num2) pairs, one per clock -> each result one edge later matches {C4,ans}=num1+num2. Spot checks:
  - 7+8 -> ans=15, C4=0.
  - 15+15 -> ans=14, C4=1.
- Subtract sweep: M=1, all 256 pairs -> ans=(num1-num2)&15, C4=(num1>=num2). Spot checks:
  - 9-3 -> ans=6, C4=1.
  - 3-9 -> ans=10, C4=0.
  - 15-15 -> ans=0, C4=1.
- Wrap boundaries, back-to-back cycles:
  - M=0 15+1 -> ans=0, C4=1.
  - Then M=1 0-1 -> ans=15, C4=0.
- Mode toggle each cycle with fixed num1=5, num2=2 -> outputs alternate:
  - ans=7, C4=0 (add).
  - ans=3, C4=1 (subtract).
  - Exactly one-cycle latency.
- Reset mid-stream: assert rst_n during a sweep -> outputs clear at once; first post-release edge shows the correct result for the inputs then present.

Source files
------------

// File: rtl/adder_subtractor_4_bit_pkg.sv
// Shared constants for the 4-bit adder/subtractor: datapath width and mode encodings.
package adder_subtractor_4_bit_pkg;

    localparam int WIDTH = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/adder_subtractor_4_bit_full_adder.sv
// One-bit full adder cell; the carry-out is the majority of the three inputs.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_subtractor_4_bit.sv
// 4-bit ripple-carry adder/subtractor with registered result and carry.
// Subtraction is num1 + ~num2 + 1, so C4 doubles as the no-borrow flag.
module adder_subtractor_4_bit
    import adder_subtractor_4_bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             M,
    output logic [WIDTH-1:0] ans,
    output logic             C4
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;
    logic             sub_mode;

    logic [WIDTH-1:0] ans_reg;
    logic             c4_reg;

    assign sub_mode = (M == MODE_SUB);
    assign carry[0] = sub_mode;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
            assign b_eff[gi] = num2[gi] ^ sub_mode;

            full_adder u_fa (
                .a    (num1[gi]),
                .b    (b_eff[gi]),
                .cin  (carry[gi]),
                .sum  (sum_next[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ans_reg <= '0;
            c4_reg  <= 1'b0;
        end else begin
            ans_reg <= sum_next;
            c4_reg  <= carry[WIDTH];
        end
    end

    assign ans = ans_reg;
    assign C4  = c4_reg;

endmodule

// File: tb/tb_adder_subtractor_4_bit.sv
// Scoreboard bench for adder_subtractor_4_bit: stimulus pushes expected results,
// a monitor pops and compares one clock later.
module tb_adder_subtractor_4_bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] num1;
    logic [3:0] num2;
    logic       M;
    logic [3:0] ans;
    logic       C4;

    int tests_run  = 0;
    int tests_fail = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       m;
        logic [3:0] ans;
        logic       c;
        string      tag;
    } exp_t;

    exp_t sb[$];

    adder_subtractor_4_bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .num1  (num1),
        .num2  (num2),
        .M     (M),
        .ans   (ans),
        .C4    (C4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b,
                                   input logic m, input string tag);
        exp_t e;
        int   s;
        e.a = a; e.b = b; e.m = m; e.tag = tag;
        if (!m) begin
            s     = int'(a) + int'(b);
            e.ans = 4'(s);
            e.c   = (s > 15);
        end else begin
            s     = int'(a) - int'(b) + 16;
            e.ans = 4'(s);
            e.c   = (a >= b);
        end
        return e;
    endfunction

    task automatic drive_push(input exp_t e);
        @(negedge clk);
        num1 = e.a;
        num2 = e.b;
        M    = e.m;
        sb.push_back(e);
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b,
                         input logic m, input string tag);
        drive_push(model(a, b, m, tag));
    endtask

    task automatic apply_exp(input logic [3:0] a, input logic [3:0] b, input logic m,
                             input logic [3:0] x_ans, input logic x_c, input string tag);
        exp_t e;
        e.a = a; e.b = b; e.m = m; e.ans = x_ans; e.c = x_c; e.tag = tag;
        drive_push(e);
    endtask

    task automatic check_zero(input string tag);
        tests_run++;
        if (ans !== 4'd0 || C4 !== 1'b0) begin
            tests_fail++;
            $display("FAIL %s: got ans=%0d C4=%0b want ans=0 C4=0", tag, ans, C4);
        end else begin
            $display("[TB] %s: ans=%0d C4=%0b ok", tag, ans, C4);
        end
    endtask

    // Monitor: the registered outputs present a new result every enabled clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                tests_run++;
                if (ans !== e.ans || C4 !== e.c) begin
                    tests_fail++;
                    $display("FAIL %s: num1=%0d num2=%0d M=%0b got ans=%0d C4=%0b want ans=%0d C4=%0b",
                             e.tag, e.a, e.b, e.m, ans, C4, e.ans, e.c);
                end else begin
                    $display("[TB] %s: num1=%0d num2=%0d M=%0b ans=%0d C4=%0b ok",
                             e.tag, e.a, e.b, e.m, ans, C4);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        rst_n = 1'b1;
        num1  = 4'd9;
        num2  = 4'd3;
        M     = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_zero("reset_async");
        repeat (2) @(posedge clk);
        #1 check_zero("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // Spot checks with hand-derived expectations.
        apply_exp(4'd7,  4'd8,  1'b0, 4'd15, 1'b0, "add_7_8");
        apply_exp(4'd15, 4'd15, 1'b0, 4'd14, 1'b1, "add_15_15");
        apply_exp(4'd9,  4'd3,  1'b1, 4'd6,  1'b1, "sub_9_3");
        apply_exp(4'd3,  4'd9,  1'b1, 4'd10, 1'b0, "sub_3_9");
        apply_exp(4'd15, 4'd15, 1'b1, 4'd0,  1'b1, "sub_15_15");
        apply_exp(4'd0,  4'd0,  1'b1, 4'd0,  1'b1, "sub_0_0");
        apply_exp(4'd15, 4'd1,  1'b0, 4'd0,  1'b1, "wrap_add_15_1");
        apply_exp(4'd0,  4'd1,  1'b1, 4'd15, 1'b0, "wrap_sub_0_1");

        // Mode toggles every cycle with fixed operands.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) apply_exp(4'd5, 4'd2, 1'b0, 4'd7, 1'b0, "toggle_add");
            else            apply_exp(4'd5, 4'd2, 1'b1, 4'd3, 1'b1, "toggle_sub");
        end

        // Exhaustive sweeps, one pair per clock.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                apply(4'(a), 4'(b), 1'b0, "add_sweep");
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                apply(4'(a), 4'(b), 1'b1, "sub_sweep");

        // Reset mid-stream: the in-flight operation is discarded.
        apply(4'd9, 4'd3, 1'b0, "pre_reset");
        apply(4'd4, 4'd6, 1'b1, "inflight");
        #2 rst_n = 1'b0;
        sb.delete();
        #1 check_zero("reset_midstream");
        @(posedge clk);
        #1 check_zero("reset_midstream_hold");
        @(negedge clk);
        num1  = 4'd11;
        num2  = 4'd13;
        M     = 1'b1;
        sb.push_back(model(4'd11, 4'd13, 1'b1, "post_release"));
        rst_n = 1'b1;

        // Random traffic with random mode.
        for (int i = 0; i < 200; i++)
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), "random");

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        tests_run++;
        if (sb.size() != 0) begin
            tests_fail++;
            $display("FAIL drain: got %0d pending results want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
